// File: rtl/fp_pkg.sv
// Shared types and width helpers for the parametrised floating-point add/sub unit.
// Widths are functions of the exponent/fraction widths so one package serves every format.
package fp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    // Guard, round and sticky bits carried below the fraction.
    localparam int unsigned GrsW = 3;
    // Widest supported word; format constants are built at this width, then truncated.
    localparam int unsigned MaxW = 128;

    function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Working significand: hidden bit, fraction, guard, round, sticky.
    function automatic int unsigned sig_w(input int unsigned man_w);
        return man_w + 1 + GrsW;
    endfunction

    function automatic logic [MaxW-1:0] qnan_word(input int unsigned exp_w,
                                                  input int unsigned man_w);
        logic [MaxW-1:0] one;
        one = MaxW'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for fp_addsub; master drives operands, slave is the unit.
interface fp_addsub_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] rez;
    logic         out_valid;
    logic         out_ready;
    logic         flag_nv;
    logic         flag_of;
    logic         flag_nx;

    modport master (
        output a, b, sub, in_valid, out_ready,
        input  in_ready, rez, out_valid, flag_nv, flag_of, flag_nx
    );

    modport slave (
        input  a, b, sub, in_valid, out_ready,
        output in_ready, rez, out_valid, flag_nv, flag_of, flag_nx
    );
endinterface

// File: rtl/lzc.sv
// Leading-zero counter; an all-zero input reports Width.
module lzc #(
    parameter int unsigned Width = 27,
    localparam int unsigned CntW = $clog2(Width + 1)
) (
    input  logic [Width-1:0] val,
    output logic [CntW-1:0]  cnt
);
    logic [Width-1:0] sh;

    // Scan upward so the most significant set bit writes last.
    always_comb begin
        cnt = CntW'(Width);
        sh  = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            sh = val >> i;
            if (sh[0]) begin
                cnt = CntW'(Width - 1 - i);
            end
        end
    end
endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle floating-point adder/subtractor, round-to-nearest-even, flush-to-zero,
// valid/ready on both sides; result and flags are held until the consumer takes them.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic        clk,
    input logic        reset,
    fp_addsub_if.slave bus
);
    localparam int unsigned W     = word_w(EXP_W, MAN_W);
    localparam int unsigned F     = sig_w(MAN_W);
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned ShMax = MAN_W + GrsW;
    localparam int unsigned ShW   = $clog2(ShMax + 1);
    localparam int unsigned CntW  = $clog2(F + 1);
    localparam logic [MaxW-1:0] QNanFull = qnan_word(EXP_W, MAN_W);
    localparam logic [W-1:0]    QNan     = QNanFull[W-1:0];
    localparam logic [EW-1:0]   ExpMax   = {2'b00, {EXP_W{1'b1}}};

    state_e state_q, state_d;
    logic   align_ph_q;

    logic             sign_a_q, sign_b_q, eff_sub_q;
    logic [EXP_W-1:0] exp_a_q, exp_b_q;
    logic [MAN_W:0]   sig_a_q, sig_b_q;
    logic             special_q, spec_nv_q;
    logic [W-1:0]     spec_rez_q;
    logic             sign_r_q;
    logic [EW-1:0]    exp_r_q;
    logic [F-1:0]     big_q, small_q;
    logic [ShW-1:0]   shamt_q;
    logic [F:0]       sum_q;
    logic [F-1:0]     mant_q;
    logic             zero_q;
    logic [W-1:0]     rez_q;
    logic             nv_q, of_q, nx_q;

    // Operand unpack and special-case resolution at capture.
    logic [EXP_W-1:0] in_exp_a, in_exp_b;
    logic [MAN_W-1:0] in_frac_a, in_frac_b;
    logic             in_sign_a, in_sign_b, in_eff_sub;
    logic             a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             in_special, in_spec_nv;
    logic [W-1:0]     in_spec_rez;

    always_comb begin
        in_sign_a   = bus.a[W-1];
        in_exp_a    = bus.a[W-2:MAN_W];
        in_frac_a   = bus.a[MAN_W-1:0];
        in_sign_b   = bus.b[W-1] ^ bus.sub;
        in_exp_b    = bus.b[W-2:MAN_W];
        in_frac_b   = bus.b[MAN_W-1:0];
        in_eff_sub  = in_sign_a ^ in_sign_b;
        a_nan       = (&in_exp_a) && (|in_frac_a);
        b_nan       = (&in_exp_b) && (|in_frac_b);
        a_inf       = (&in_exp_a) && !(|in_frac_a);
        b_inf       = (&in_exp_b) && !(|in_frac_b);
        a_snan      = a_nan && !in_frac_a[MAN_W-1];
        b_snan      = b_nan && !in_frac_b[MAN_W-1];
        in_special  = 1'b1;
        in_spec_nv  = 1'b0;
        in_spec_rez = QNan;
        if (a_nan || b_nan) begin
            in_spec_nv = a_snan || b_snan;
        end else if (a_inf && b_inf && in_eff_sub) begin
            in_spec_nv = 1'b1;
        end else if (a_inf) begin
            in_spec_rez = {in_sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            in_spec_rez = {in_sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            in_special = 1'b0;
        end
    end

    // Alignment: first phase orders by magnitude, second phase shifts with sticky collection.
    logic             a_ge;
    logic [EXP_W-1:0] exp_big, exp_small;
    logic [MAN_W:0]   sig_big, sig_small;
    int unsigned      diff;
    logic [ShW-1:0]   shamt_c;
    logic [2*F-1:0]   shift_wide;
    logic [F-1:0]     small_shifted;

    always_comb begin
        a_ge          = {exp_a_q, sig_a_q} >= {exp_b_q, sig_b_q};
        exp_big       = a_ge ? exp_a_q : exp_b_q;
        exp_small     = a_ge ? exp_b_q : exp_a_q;
        sig_big       = a_ge ? sig_a_q : sig_b_q;
        sig_small     = a_ge ? sig_b_q : sig_a_q;
        diff          = 32'(exp_big) - 32'(exp_small);
        shamt_c       = (diff > ShMax) ? ShW'(ShMax) : ShW'(diff);
        shift_wide    = {small_q, {F{1'b0}}} >> shamt_q;
        small_shifted = {shift_wide[2*F-1:F+1], shift_wide[F] | (|shift_wide[F-1:0])};
    end

    logic [F:0] sum_c;
    assign sum_c = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                             : ({1'b0, big_q} + {1'b0, small_q});

    logic [CntW-1:0] lz;
    logic [F-1:0]    mant_c;
    logic [EW-1:0]   exp_n;
    logic            zero_c;

    lzc #(
        .Width(F)
    ) u_lzc (
        .val(sum_q[F-1:0]),
        .cnt(lz)
    );

    always_comb begin
        zero_c = (sum_q == '0);
        if (sum_q[F]) begin
            mant_c = {sum_q[F:2], sum_q[1] | sum_q[0]};
            exp_n  = exp_r_q + EW'(1);
        end else begin
            mant_c = sum_q[F-1:0] << lz;
            exp_n  = exp_r_q - EW'(lz);
        end
    end

    // Rounding and packing; exp_f is kept two bits wider so overflow and underflow are visible.
    logic [MAN_W+1:0] rnd;
    logic             rnd_up, inexact;
    logic [EW-1:0]    exp_f;
    logic [MAN_W-1:0] frac_f;
    logic [W-1:0]     rez_c;
    logic             nv_c, of_c, nx_c;

    always_comb begin
        inexact = |mant_q[2:0];
        rnd_up  = mant_q[2] && (mant_q[1] || mant_q[0] || mant_q[3]);
        rnd     = {1'b0, mant_q[F-1:GrsW]} + {{(MAN_W+1){1'b0}}, rnd_up};
        exp_f   = rnd[MAN_W+1] ? exp_r_q + EW'(1) : exp_r_q;
        frac_f  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        rez_c   = {sign_r_q, exp_f[EXP_W-1:0], frac_f};
        nv_c    = 1'b0;
        of_c    = 1'b0;
        nx_c    = inexact;
        if (special_q) begin
            rez_c = spec_rez_q;
            nv_c  = spec_nv_q;
            nx_c  = 1'b0;
        end else if (zero_q) begin
            rez_c = {sign_r_q && !eff_sub_q, {(W-1){1'b0}}};
            nx_c  = 1'b0;
        end else if (!exp_f[EW-1] && exp_f >= ExpMax) begin
            rez_c = {sign_r_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_c  = 1'b1;
            nx_c  = 1'b1;
        end else if (exp_f[EW-1] || exp_f == '0) begin
            rez_c = {sign_r_q, {(W-1){1'b0}}};
            nx_c  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid) state_d = StAlign;
            StAlign: if (align_ph_q) state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            align_ph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            align_ph_q <= (state_q == StAlign) && !align_ph_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            eff_sub_q  <= 1'b0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            sig_a_q    <= '0;
            sig_b_q    <= '0;
            special_q  <= 1'b0;
            spec_nv_q  <= 1'b0;
            spec_rez_q <= '0;
            sign_r_q   <= 1'b0;
            exp_r_q    <= '0;
            big_q      <= '0;
            small_q    <= '0;
            shamt_q    <= '0;
            sum_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            rez_q      <= '0;
            nv_q       <= 1'b0;
            of_q       <= 1'b0;
            nx_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        sign_a_q   <= in_sign_a;
                        sign_b_q   <= in_sign_b;
                        eff_sub_q  <= in_eff_sub;
                        exp_a_q    <= in_exp_a;
                        exp_b_q    <= in_exp_b;
                        sig_a_q    <= (in_exp_a == '0) ? '0 : {1'b1, in_frac_a};
                        sig_b_q    <= (in_exp_b == '0) ? '0 : {1'b1, in_frac_b};
                        special_q  <= in_special;
                        spec_nv_q  <= in_spec_nv;
                        spec_rez_q <= in_spec_rez;
                    end
                end
                StAlign: begin
                    if (!align_ph_q) begin
                        sign_r_q <= a_ge ? sign_a_q : sign_b_q;
                        exp_r_q  <= {2'b00, exp_big};
                        big_q    <= {sig_big, {GrsW{1'b0}}};
                        small_q  <= {sig_small, {GrsW{1'b0}}};
                        shamt_q  <= shamt_c;
                    end else begin
                        small_q <= small_shifted;
                    end
                end
                StAdd: sum_q <= sum_c;
                StNorm: begin
                    mant_q  <= mant_c;
                    exp_r_q <= exp_n;
                    zero_q  <= zero_c;
                end
                StRound: begin
                    rez_q <= rez_c;
                    nv_q  <= nv_c;
                    of_q  <= of_c;
                    nx_q  <= nx_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.rez       = rez_q;
    assign bus.flag_nv   = nv_q;
    assign bus.flag_of   = of_q;
    assign bus.flag_nx   = nx_q;
endmodule
